// File: rtl/alu_pkg.sv
// alu_pkg: shared function codes and sequencer state encoding for the ALU command front end
package alu_pkg;

    typedef enum logic [1:0] {
        FN_ADD     = 2'd0,
        FN_OR_RED  = 2'd1,
        FN_AND_RED = 2'd2,
        FN_CONCAT  = 2'd3
    } alu_fn_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_A  = 2'd1,
        EXEC   = 2'd2,
        RESULT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_eval.sv
// alu_eval: combinational evaluation of one ALU function on two N-bit operands
//   fn     : function code (alu_fn_t)
//   a, b   : N-bit operands
//   result : 2N-bit result, zero-extended
module alu_eval
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  alu_fn_t          fn,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [2*N-1:0]   result
);

    logic [2*N-1:0] sum;

    always_comb begin
        sum    = (2*N)'(a) + (2*N)'(b);
        result = fn == FN_ADD     ? sum :
                 fn == FN_OR_RED  ? (2*N)'((|a) | (|b)) :
                 fn == FN_AND_RED ? (2*N)'((&a) & (&b)) :
                                    {a, b};
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: collects A/B operand beats, evaluates one ALU function, returns a registered result
//   Clock, Reset         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : operand stream; first beat carries A and Function, second beat B
//   Function, Data       : operation code (A beat only) and N-bit operand
//   out_valid/out_ready  : result stream; ALUOut held until accepted
//   ALUOut               : 2N-bit registered result, kept after the handshake
//   busy                 : high whenever not IDLE
//   Zero, Carry          : result flags, present only when ALU_FLAGS_EN is defined
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     Function,
    input  logic [N-1:0]   Data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] ALUOut,
    output logic           busy
`ifdef ALU_FLAGS_EN
    ,
    output logic           Zero,
    output logic           Carry
`endif
);

    seq_state_t     state_q, state_d;
    alu_fn_t        fn_q, fn_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [2*N-1:0] alu_out_q, alu_out_d, result;
    logic           out_valid_q, out_valid_d;

    alu_eval #(.N(N)) u_eval (
        .fn     (fn_q),
        .a      (a_q),
        .b      (b_q),
        .result (result)
    );

    assign in_ready  = state_q == IDLE || state_q == GOT_A;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign ALUOut    = alu_out_q;

    always_comb begin
        state_d     = state_q;
        fn_d        = fn_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_out_d   = alu_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = Data;
                fn_d    = alu_fn_t'(Function);
                state_d = GOT_A;
            end
            GOT_A: if (in_valid) begin
                b_d     = Data;
                state_d = EXEC;
            end
            EXEC: begin
                alu_out_d   = result;
                out_valid_d = 1'b1;
                state_d     = RESULT;
            end
            default: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            fn_q        <= FN_ADD;
            a_q         <= '0;
            b_q         <= '0;
            alu_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fn_q        <= fn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_out_q   <= alu_out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic zero_q, zero_d, carry_q, carry_d;

    // flags load only on the EXEC edge so they stay paired with ALUOut
    always_comb begin
        zero_d  = state_q == EXEC ? result == '0 : zero_q;
        carry_d = state_q == EXEC ? (fn_q == FN_ADD && result[N]) : carry_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign Zero  = zero_q;
    assign Carry = carry_q;
`endif

endmodule
